// File: rtl/result_buf_pkg.sv
// Shared defaults and types for the result-buffer controller.
package result_buf_pkg;

  localparam int RB_DEPTH = 14;
  localparam int RB_CW    = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef enum logic {
    GNT_WR,
    GNT_RD
  } grant_t;

  // Bit positions of the write and read requesters on the arbiter bus.
  localparam int REQ_WR = 0;
  localparam int REQ_RD = 1;

endpackage

// File: rtl/result_buf_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, ties go to
// whichever side was not granted most recently.
module rr_arb2
  import result_buf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output grant_t     last_gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == GNT_WR) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Resetting to "write" lets the read side win the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt <= GNT_WR;
    end else if (gnt[REQ_RD]) begin
      last_gnt <= GNT_RD;
    end else if (gnt[REQ_WR]) begin
      last_gnt <= GNT_WR;
    end
  end

endmodule

// File: rtl/result_buf_ctrl.sv
// Result-buffer controller: frame FSM, single-port write/read arbitration,
// occupancy tracking and wrapping shadow address counters.
module result_buf_ctrl
  import result_buf_pkg::*;
#(
  parameter int DEPTH = RB_DEPTH,
  parameter int CW    = RB_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          drain,
  input  logic          wr_req,
  input  logic          rd_req,
  output logic          write_en,
  output logic          read_en,
  output logic [CW-1:0] wr_addr,
  output logic [CW-1:0] rd_addr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_ADDR  = CW'(DEPTH - 1);

  state_t        state;
  state_t        state_next;
  logic [1:0]    req;
  logic [1:0]    gnt;
  grant_t        last_gnt;
  logic [CW-1:0] count_next;
  logic          done_next;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign busy  = (state != IDLE);

  // Writes only while the frame is running; reads continue through DRAIN.
  assign req[REQ_WR] = (state == RUN) && wr_req && !full;
  assign req[REQ_RD] = (state != IDLE) && rd_req && !empty;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .gnt      (gnt),
    .last_gnt (last_gnt)
  );

  assign write_en = gnt[REQ_WR];
  assign read_en  = gnt[REQ_RD];

  always_comb begin
    count_next = count;
    if (write_en) begin
      count_next = count + 1'b1;
    end else if (read_en) begin
      count_next = count - 1'b1;
    end
  end

  // DRAIN exits on the edge the buffer becomes (or already is) empty.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (drain) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (count_next == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      wr_addr <= '0;
      rd_addr <= '0;
    end else begin
      count <= count_next;
      if (write_en) begin
        wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
      end
      if (read_en) begin
        rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
      end
    end
  end

  // Occupancy bounds and grant exclusivity must hold in every cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(write_en && read_en));
      assert (count <= FULL_COUNT);
      assert (!(write_en && full));
      assert (!(read_en && empty));
      if (req == 2'b11) begin
        assert (gnt[REQ_RD] == (last_gnt == GNT_WR));
      end
    end
  end

endmodule

// File: tb/tb_result_buf_ctrl.sv
// Directed and soak bench for result_buf_ctrl against a queue-based FIFO model.
module tb_result_buf_ctrl;

  localparam int DEPTH = 14;
  localparam int CW    = 4;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          start  = 1'b0;
  logic          drain  = 1'b0;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic          write_en;
  logic          read_en;
  logic [CW-1:0] wr_addr;
  logic [CW-1:0] rd_addr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          busy;
  logic          done;

  int vectors     = 0;
  int miscompares = 0;

  // Model: frame mode (0 idle, 1 run, 2 drain), FIFO of written addresses,
  // lifetime write/read totals and who won the last grant.
  int modelMode   = 0;
  int modelQ[$];
  int wrTotal     = 0;
  int rdTotal     = 0;
  bit lastWasRead = 1'b0;
  bit modelDone   = 1'b0;

  bit obsWe;
  bit obsRe;
  bit obsDone;

  result_buf_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .drain    (drain),
    .wr_req   (wr_req),
    .rd_req   (rd_req),
    .write_en (write_en),
    .read_en  (read_en),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelGrant(output bit gw, output bit gr);
    bit ew;
    bit er;
    ew = (modelMode == 1) && wr_req && (modelQ.size() < DEPTH);
    er = (modelMode != 0) && rd_req && (modelQ.size() > 0);
    gw = 1'b0;
    gr = 1'b0;
    if (ew && er) begin
      if (lastWasRead) gw = 1'b1;
      else             gr = 1'b1;
    end else begin
      gw = ew;
      gr = er;
    end
  endfunction

  always @(posedge clk or posedge reset) begin : model_update
    bit gw;
    bit gr;
    if (reset) begin
      modelMode   = 0;
      modelQ.delete();
      wrTotal     = 0;
      rdTotal     = 0;
      lastWasRead = 1'b0;
      modelDone   = 1'b0;
    end else begin
      modelGrant(gw, gr);
      if (gw) begin
        modelQ.push_back(wrTotal % DEPTH);
        wrTotal++;
        lastWasRead = 1'b0;
      end
      if (gr) begin
        void'(modelQ.pop_front());
        rdTotal++;
        lastWasRead = 1'b1;
      end
      modelDone = 1'b0;
      case (modelMode)
        0: if (start) modelMode = 1;
        1: if (drain) modelMode = 2;
        2: if (modelQ.size() == 0) begin
             modelMode = 0;
             modelDone = 1'b1;
           end
        default: modelMode = 0;
      endcase
    end
  end

  always @(negedge clk) begin : compare
    bit gw;
    bit gr;
    if (!reset) begin
      modelGrant(gw, gr);
      checkOutput("write_en", int'(write_en), int'(gw));
      checkOutput("read_en",  int'(read_en),  int'(gr));
      checkOutput("wr_addr",  int'(wr_addr),  wrTotal % DEPTH);
      checkOutput("rd_addr",  int'(rd_addr),  rdTotal % DEPTH);
      checkOutput("count",    int'(count),    modelQ.size());
      checkOutput("full",     int'(full),     int'(modelQ.size() == DEPTH));
      checkOutput("empty",    int'(empty),    int'(modelQ.size() == 0));
      checkOutput("busy",     int'(busy),     int'(modelMode != 0));
      checkOutput("done",     int'(done),     int'(modelDone));
      if (gr && modelQ.size() > 0) begin
        checkOutput("fifo_order", int'(rd_addr), modelQ[0]);
      end
    end
  end

  // One cycle: drive at posedge+1, observe at negedge, return after the edge.
  task automatic applyStimulus(input bit s, input bit d, input bit w, input bit r);
    start  = s;
    drain  = d;
    wr_req = w;
    rd_req = r;
    @(negedge clk);
    obsWe   = write_en;
    obsRe   = read_en;
    obsDone = done;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    start  = 1'b0;
    drain  = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int w;
    int r;
    int tail;
    int both;
    int seqBits;
    int doneSeen;
    int doneAt;
    int pw;
    int pr;
    int pwTab[4];
    int prTab[4];

    pwTab = '{80, 20, 50, 95};
    prTab = '{20, 80, 50, 95};

    // Reset values
    doReset();
    checkOutput("rst_count",    int'(count),    0);
    checkOutput("rst_empty",    int'(empty),    1);
    checkOutput("rst_full",     int'(full),     0);
    checkOutput("rst_busy",     int'(busy),     0);
    checkOutput("rst_done",     int'(done),     0);
    checkOutput("rst_wr_addr",  int'(wr_addr),  0);
    checkOutput("rst_rd_addr",  int'(rd_addr),  0);

    // Fill past capacity: 14 writes, then refused
    applyStimulus(1, 0, 0, 0);
    checkOutput("fill_busy", int'(busy), 1);
    w = 0;
    tail = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 1, 0);
      if (obsWe) begin
        w++;
        if (i >= 14) tail++;
      end
    end
    checkOutput("fill_writes",  w,              14);
    checkOutput("fill_tail_we", tail,           0);
    checkOutput("fill_count",   int'(count),    14);
    checkOutput("fill_full",    int'(full),     1);
    checkOutput("fill_wr_addr", int'(wr_addr),  0);

    // Tie arbitration from count=5: R,W,R,W,R,W
    doReset();
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0);
    checkOutput("tie_pre_count", int'(count), 5);
    seqBits = 0;
    both = 0;
    w = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 1, 1);
      if (obsWe && obsRe) both++;
      if (obsWe || obsRe) w++;
      seqBits = (seqBits << 1) | int'(obsRe);
    end
    checkOutput("tie_sequence", seqBits,        42);
    checkOutput("tie_grants",   w,              6);
    checkOutput("tie_both",     both,           0);
    checkOutput("tie_count",    int'(count),    5);
    checkOutput("tie_wr_addr",  int'(wr_addr),  8);
    checkOutput("tie_rd_addr",  int'(rd_addr),  3);

    // Write 3, drain with reads held
    doReset();
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 1);
    r = int'(obsRe);
    doneSeen = 0;
    doneAt = -1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1);
      if (obsRe) r++;
      if (obsDone) begin
        doneSeen++;
        doneAt = i;
      end
    end
    checkOutput("drain_reads",   r,              3);
    checkOutput("drain_rd_addr", int'(rd_addr),  3);
    checkOutput("drain_done_n",  doneSeen,       1);
    checkOutput("drain_done_at", doneAt,         2);
    checkOutput("drain_busy",    int'(busy),     0);
    checkOutput("drain_count",   int'(count),    0);

    // Writes refused in DRAIN; drain on an empty buffer
    doReset();
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    w = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0);
      if (obsWe) w++;
    end
    checkOutput("drainwr_we",    w,           0);
    checkOutput("drainwr_count", int'(count), 2);
    checkOutput("drainwr_busy",  int'(busy),  1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 1);
    checkOutput("drainwr_idle",  int'(busy),  0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("empty_drain_busy", int'(busy), 1);
    checkOutput("empty_drain_done", int'(done), 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("empty_done_pulse", int'(done), 1);
    checkOutput("empty_done_busy",  int'(busy), 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("empty_done_clear", int'(done), 0);

    // Reset mid-RUN with count=9
    doReset();
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 0);
    checkOutput("abort_pre_count", int'(count), 9);
    wr_req = 1'b1;
    reset  = 1'b1;
    #2;
    checkOutput("abort_count", int'(count),    0);
    checkOutput("abort_empty", int'(empty),    1);
    checkOutput("abort_busy",  int'(busy),     0);
    checkOutput("abort_done",  int'(done),     0);
    checkOutput("abort_we",    int'(write_en), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    w = 0;
    doneSeen = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0);
      if (obsWe) w++;
      if (obsDone) doneSeen++;
    end
    checkOutput("abort_ignore_we", w,           0);
    checkOutput("abort_no_done",   doneSeen,    0);
    checkOutput("abort_count2",    int'(count), 0);

    // Random soak with varying write/read pressure
    doReset();
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 10000; i++) begin
      pw = pwTab[(i / 500) % 4];
      pr = prTab[(i / 500) % 4];
      applyStimulus($urandom_range(0, 199) == 0,
                    1'b0,
                    $urandom_range(0, 99) < pw,
                    $urandom_range(0, 99) < pr);
    end
    applyStimulus(0, 1, 0, 1);
    for (int i = 0; i < 20 && busy; i++) applyStimulus(0, 0, 0, 1);
    checkOutput("soak_end_busy",  int'(busy),  0);
    checkOutput("soak_end_count", int'(count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/result_buf_ctrl.md
RESULT_BUF_CTRL -- requirements
Module: result_buf_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 14, meaning result-buffer entries; the address counters wrap at DEPTH-1 (13).
REQ-002 SHALL have parameter CW, default 4, meaning the width of addresses and occupancy.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse; begins a frame.
REQ-007 drain  input  1  single-cycle pulse; ends the frame after the buffer empties.
REQ-008 wr_req  input  1  producer (conv/pool output) holds one result.
REQ-009 rd_req  input  1  consumer (next layer) wants one result.
REQ-010 write_en  output  1  advances the in_address counter; also acks the producer.
REQ-011 read_en  output  1  advances the out_address counter; also acks the consumer.
REQ-012 wr_addr  output  CW  shadow of in_address, range 0..DEPTH-1.
REQ-013 rd_addr  output  CW  shadow of out_address, range 0..DEPTH-1.
REQ-014 count  output  CW  occupancy, range 0..DEPTH.
REQ-015 full, empty  output  1 each  full is count==DEPTH; empty is count==0.
REQ-016 busy  output  1  FSM is not IDLE.
REQ-017 done  output  1  one-cycle pulse on the DRAIN->IDLE transition.

Function
REQ-018 SHALL implement the FSM states IDLE, RUN and DRAIN.
REQ-019 IDLE->RUN SHALL occur on start; start is ignored outside IDLE.
REQ-020 RUN->DRAIN SHALL occur on drain; drain is ignored outside RUN.
REQ-021 DRAIN->IDLE SHALL occur on the edge where count becomes 0, or at once if count is already 0 on entry.
REQ-022 In IDLE, write_en and read_en SHALL be 0, and count and the pointers SHALL be held.
REQ-023 Write eligibility SHALL be: state==RUN and wr_req and !full.
REQ-024 Read eligibility SHALL be: state in {RUN, DRAIN} and rd_req and !empty.
REQ-025 write_en and read_en SHALL never be 1 in the same cycle, because the downstream counter serves only one per cycle.
REQ-026 When exactly one requester is eligible, it SHALL be granted.
REQ-027 When both are eligible, the requester not granted most recently SHALL be granted; the last-grant flag resets to "write", so read wins the first tie.
REQ-028 Grants SHALL be combinational from the registered state and the current requests (0-cycle latency), and a request SHALL be held until acked.
REQ-029 On the clock edge after a grant, count SHALL change by +1 for a write and -1 for a read, and the granted pointer SHALL increment, wrapping DEPTH-1 -> 0.
REQ-030 The sequence full -> read grant -> write grant SHALL be legal, while a write in the same cycle as full SHALL be refused.
REQ-031 count SHALL never exceed DEPTH or underflow below 0; an assertion SHALL flag any violation.
REQ-032 done SHALL be registered and high for exactly one cycle.

Reset
REQ-033 Reset SHALL set state=IDLE, count=0, wr_addr=0, rd_addr=0, done=0 and last-grant=write, giving empty=1, full=0, busy=0, write_en=0 and read_en=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately, with no done pulse; the address counters share the same reset, so the pointers stay aligned.

Structure
REQ-035 Package result_buf_pkg SHALL hold the DEPTH and CW defaults and the state enum {IDLE, RUN, DRAIN}.
REQ-036 The two-way round-robin arbiter SHALL be a sub-module named rr_arb2 (inputs req[1:0]; outputs gnt[1:0] and the last-grant register).
REQ-037 The FSM, occupancy and pointers SHALL reside in result_buf_ctrl.

Verification
REQ-038 Reset, start, then wr_req held for 16 cycles -> 14 write_en pulses, then full=1 and count=14, wr_addr=0 after the wrap, and write_en=0 for the remaining 2 cycles.
REQ-039 From count=5, wr_req and rd_req both held for 6 cycles -> grants alternate starting with read (R,W,R,W,R,W), count ends at 5, and write_en and read_en are never both 1.
REQ-040 Write 3, pulse drain, keep rd_req=1 -> 3 read_en pulses with rd_addr 0->3, done high for 1 cycle when count hits 0, then state IDLE and busy=0.
REQ-041 During DRAIN, wr_req=1 -> write_en stays 0; pulsing drain with count=0 -> done on the next cycle.
REQ-042 Assert reset mid-RUN with count=9 -> the next cycle shows count=0, empty=1, busy=0, no done pulse, and wr_req is ignored until start.
REQ-043 Run a random wr_req/rd_req soak of 10k cycles against a FIFO model -> no overflow or underflow, and the shadow pointers match the model modulo 14.
